// File: rtl/operand_fetch_if.sv
// ============================================================================
//  operand_fetch_if : instruction-in / operand-out bus of operand_fetch,
//                     including register-file read and write-snoop ports.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface operand_fetch_if #(
  parameter int DATA_WIDTH_P = 32,
  parameter int ADDR_WIDTH_P = 5
);
  logic                    i_instr_valid;
  logic                    o_instr_ready;
  logic [31:0]             i_instr;
  logic                    i_flush;
  logic [ADDR_WIDTH_P-1:0] o_rf_rd_addr_a;
  logic [ADDR_WIDTH_P-1:0] o_rf_rd_addr_b;
  logic [DATA_WIDTH_P-1:0] i_rf_rd_data_a;
  logic [DATA_WIDTH_P-1:0] i_rf_rd_data_b;
  logic                    i_wb_enable;
  logic [ADDR_WIDTH_P-1:0] i_wb_addr;
  logic [DATA_WIDTH_P-1:0] i_wb_data;
  logic                    o_op_valid;
  logic                    i_op_ready;
  logic [DATA_WIDTH_P-1:0] o_op_a;
  logic [DATA_WIDTH_P-1:0] o_op_b;
  logic [ADDR_WIDTH_P-1:0] o_op_rd;
  logic [31:0]             o_op_instr;

  modport slave (
    input  i_instr_valid, i_instr, i_flush, i_rf_rd_data_a, i_rf_rd_data_b,
           i_wb_enable, i_wb_addr, i_wb_data, i_op_ready,
    output o_instr_ready, o_rf_rd_addr_a, o_rf_rd_addr_b, o_op_valid,
           o_op_a, o_op_b, o_op_rd, o_op_instr
  );

  modport master (
    output i_instr_valid, i_instr, i_flush, i_rf_rd_data_a, i_rf_rd_data_b,
           i_wb_enable, i_wb_addr, i_wb_data, i_op_ready,
    input  o_instr_ready, o_rf_rd_addr_a, o_rf_rd_addr_b, o_op_valid,
           o_op_a, o_op_b, o_op_rd, o_op_instr
  );
endinterface

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
//  operand_fetch : reads rs1/rs2 from a 1-cycle register file, forwarding
//                  same-cycle writebacks, and presents operands downstream.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module operand_fetch #(
  parameter int DATA_WIDTH_P = 32,
  parameter int ADDR_WIDTH_P = 5
) (
  input  logic            clk,
  input  logic            reset,
  operand_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    VALID   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             instr_q, instr_d;
  logic [DATA_WIDTH_P-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH_P-1:0] op_b_q, op_b_d;

  logic [ADDR_WIDTH_P-1:0] rs1;
  logic [ADDR_WIDTH_P-1:0] rs2;
  logic                    instr_ready;
  logic                    accept;

  assign rs1 = ADDR_WIDTH_P'(instr_q[19:15]);
  assign rs2 = ADDR_WIDTH_P'(instr_q[24:20]);

  // x0 reads as zero; otherwise a write landing this cycle beats the stale RF data.
  function automatic logic [DATA_WIDTH_P-1:0] fwd(
    input logic [ADDR_WIDTH_P-1:0] addr,
    input logic                    wb_en,
    input logic [ADDR_WIDTH_P-1:0] wb_addr,
    input logic [DATA_WIDTH_P-1:0] wb_data,
    input logic [DATA_WIDTH_P-1:0] rf_data
  );
    if (addr == '0)                   return '0;
    else if (wb_en && wb_addr == addr) return wb_data;
    else                              return rf_data;
  endfunction

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    instr_ready = ((state_q == IDLE) || (state_q == VALID && bus.i_op_ready))
                  && !bus.i_flush;
    accept      = bus.i_instr_valid && instr_ready;

    if (bus.i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            instr_d = bus.i_instr;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          // A write this cycle suppresses the RF read, so retry the read.
          if (!bus.i_wb_enable) state_d = CAPTURE;
        end
        CAPTURE: begin
          op_a_d  = fwd(rs1, bus.i_wb_enable, bus.i_wb_addr, bus.i_wb_data,
                        bus.i_rf_rd_data_a);
          op_b_d  = fwd(rs2, bus.i_wb_enable, bus.i_wb_addr, bus.i_wb_data,
                        bus.i_rf_rd_data_b);
          state_d = VALID;
        end
        VALID: begin
          if (bus.i_wb_enable && bus.i_wb_addr == rs1 && rs1 != '0)
            op_a_d = bus.i_wb_data;
          if (bus.i_wb_enable && bus.i_wb_addr == rs2 && rs2 != '0)
            op_b_d = bus.i_wb_data;
          if (accept) begin
            instr_d = bus.i_instr;
            state_d = ISSUE;
          end else if (bus.i_op_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign bus.o_instr_ready  = instr_ready;
  assign bus.o_rf_rd_addr_a = rs1;
  assign bus.o_rf_rd_addr_b = rs2;
  assign bus.o_op_valid     = (state_q == VALID);
  assign bus.o_op_a         = op_a_q;
  assign bus.o_op_b         = op_b_q;
  assign bus.o_op_rd        = ADDR_WIDTH_P'(instr_q[11:7]);
  assign bus.o_op_instr     = instr_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
//  tb_operand_fetch : directed vector table, corner sequences and random
//                     traffic against a register-file-level reference model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_operand_fetch;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  operand_fetch_if #(.DATA_WIDTH_P(32), .ADDR_WIDTH_P(5)) bus ();

  operand_fetch #(.DATA_WIDTH_P(32), .ADDR_WIDTH_P(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: x0 hardwired, 1-cycle read, read skipped while a write occurs.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      if (bus.i_wb_enable && bus.i_wb_addr != 5'd0) regs[bus.i_wb_addr] <= bus.i_wb_data;
      if (!bus.i_wb_enable) begin
        bus.i_rf_rd_data_a <= regs[bus.o_rf_rd_addr_a];
        bus.i_rf_rd_data_b <= regs[bus.o_rf_rd_addr_b];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  // Reference model: pending instruction, cycles left, and operands equal to
  // the architectural register contents while valid.
  logic        m_pend, m_val;
  int          m_wait;
  logic [31:0] m_instr;

  initial begin : model_upd
    logic acc;
    m_pend = 0; m_val = 0; m_wait = 0; m_instr = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pend = 0; m_val = 0; m_wait = 0; m_instr = 0;
      end else begin
        acc = bus.i_instr_valid && !bus.i_flush &&
              ((!m_pend && !m_val) || (m_val && bus.i_op_ready));
        if (bus.i_flush) begin
          m_pend = 0; m_val = 0;
        end else if (acc) begin
          m_instr = bus.i_instr; m_pend = 1; m_wait = 2; m_val = 0;
        end else if (m_pend) begin
          if (!(m_wait == 2 && bus.i_wb_enable)) m_wait--;
          if (m_wait == 0) begin m_pend = 0; m_val = 1; end
        end else if (m_val && bus.i_op_ready) begin
          m_val = 0;
        end
      end
    end
  end

  initial begin : monitor_chk
    logic exp_ready;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        chk("rst_valid", {31'b0, bus.o_op_valid}, 32'h0);
        chk("rst_op_a", bus.o_op_a, 32'h0);
        chk("rst_op_b", bus.o_op_b, 32'h0);
        chk("rst_rd", {27'b0, bus.o_op_rd}, 32'h0);
      end else begin
        exp_ready = !bus.i_flush && ((!m_pend && !m_val) || (m_val && bus.i_op_ready));
        chk("mon_valid", {31'b0, bus.o_op_valid}, {31'b0, m_val});
        chk("mon_ready", {31'b0, bus.o_instr_ready}, {31'b0, exp_ready});
        chk("mon_addr_a", {27'b0, bus.o_rf_rd_addr_a}, {27'b0, m_instr[19:15]});
        chk("mon_addr_b", {27'b0, bus.o_rf_rd_addr_b}, {27'b0, m_instr[24:20]});
        if (m_val) begin
          chk("mon_op_a", bus.o_op_a, regs[m_instr[19:15]]);
          chk("mon_op_b", bus.o_op_b, regs[m_instr[24:20]]);
          chk("mon_rd", {27'b0, bus.o_op_rd}, {27'b0, m_instr[11:7]});
          chk("mon_instr", bus.o_op_instr, m_instr);
        end
      end
    end
  end

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    int          stall;
    logic [4:0]  st_addr;
    logic [31:0] st_data;
    logic        cap_en;
    logic [4:0]  cap_addr;
    logic [31:0] cap_data;
    logic [31:0] exp_a, exp_b;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.i_wb_enable = en; bus.i_wb_addr = a; bus.i_wb_data = d;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int n;
    @(negedge clk);
    bus.i_instr_valid = 1'b1; bus.i_instr = mk(v.rs1, v.rs2, v.rd); wb(0, 0, 0);
    @(posedge clk); lat = 1;
    @(negedge clk); bus.i_instr_valid = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      wb(1, v.st_addr, v.st_data);
      @(posedge clk); lat++; @(negedge clk);
    end
    wb(0, 0, 0);
    @(posedge clk); lat++; @(negedge clk);
    wb(v.cap_en, v.cap_addr, v.cap_data);
    @(posedge clk); lat++; @(negedge clk);
    wb(0, 0, 0);
    n = 0;
    while (!bus.o_op_valid && n < 8) begin
      @(posedge clk); lat++; @(negedge clk); n++;
    end
    #1;
    chk($sformatf("vec%0d_valid", idx), {31'b0, bus.o_op_valid}, 32'h1);
    chk($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("vec%0d_op_a", idx), bus.o_op_a, v.exp_a);
    chk($sformatf("vec%0d_op_b", idx), bus.o_op_b, v.exp_b);
    chk($sformatf("vec%0d_rd", idx), {27'b0, bus.o_op_rd}, {27'b0, v.rd});
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    #1;
    while (!bus.o_op_valid && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk(name, {31'b0, bus.o_op_valid}, 32'h1);
  endtask

  initial begin : stim
    tests = 0; fails = 0;
    reset = 1'b1;
    bus.i_instr_valid = 0; bus.i_instr = 0; bus.i_flush = 0; bus.i_op_ready = 1;
    wb(0, 0, 0);

    //       rs1   rs2   rd  stall st_addr st_data cap cap_a cap_data  exp_a     exp_b    lat
    vecs[0] = '{5'd1, 5'd2, 5'd3,  0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    32'd5,    32'd7,    3};
    vecs[1] = '{5'd1, 5'd2, 5'd4,  1, 5'd9, 32'h10, 1'b0, 5'd0, 32'h0,    32'd5,    32'd7,    4};
    vecs[2] = '{5'd1, 5'd0, 5'd5,  0, 5'd0, 32'h0,  1'b1, 5'd1, 32'hDEAD, 32'hDEAD, 32'h0,    3};
    vecs[3] = '{5'd0, 5'd0, 5'd6,  0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h1234, 32'h0,    32'h0,    3};
    vecs[4] = '{5'd2, 5'd2, 5'd7,  0, 5'd0, 32'h0,  1'b1, 5'd2, 32'h55,   32'h55,   32'h55,   3};
    vecs[5] = '{5'd5, 5'd6, 5'd8,  2, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB,   32'hAA,   32'hBB,   5};
    vecs[6] = '{5'd6, 5'd1, 5'd31, 0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h1,    32'hBB,   32'hDEAD, 3};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", {31'b0, bus.o_instr_ready}, 32'h1);
    chk("reset_instr", bus.o_op_instr, 32'h0);
    @(negedge clk); reset = 1'b0;

    // Preload while idle.
    wb(1, 1, 32'd5);   @(negedge clk);
    wb(1, 2, 32'd7);   @(negedge clk);
    wb(1, 5, 32'h500); @(negedge clk);
    wb(1, 6, 32'h600); @(negedge clk);
    wb(0, 0, 0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Stall downstream, snoop a write to a held operand.
    @(negedge clk);
    bus.i_instr_valid = 1; bus.i_instr = mk(5'd1, 5'd2, 5'd4); bus.i_op_ready = 1;
    @(negedge clk); bus.i_instr_valid = 0; bus.i_op_ready = 0;
    wait_valid("hold_wait_valid");
    wb(1, 2, 32'hBEEF); bus.i_instr_valid = 1; bus.i_instr = mk(5'd3, 5'd3, 5'd3);
    #1;
    chk("hold_ready", {31'b0, bus.o_instr_ready}, 32'h0);
    chk("hold_b_before", bus.o_op_b, 32'h55);
    @(negedge clk); #1;
    chk("hold_b_after", bus.o_op_b, 32'hBEEF);
    chk("hold_valid", {31'b0, bus.o_op_valid}, 32'h1);
    wb(0, 0, 0); bus.i_instr_valid = 0; bus.i_op_ready = 1;
    @(negedge clk); #1;
    chk("hold_released", {31'b0, bus.o_op_valid}, 32'h0);

    // Flush while in CAPTURE.
    @(negedge clk);
    bus.i_instr_valid = 1; bus.i_instr = mk(5'd1, 5'd2, 5'd10);
    @(negedge clk); bus.i_instr_valid = 0;
    @(negedge clk); bus.i_flush = 1; bus.i_instr_valid = 1;
    #1;
    chk("flush_ready", {31'b0, bus.o_instr_ready}, 32'h0);
    @(negedge clk); bus.i_flush = 0; bus.i_instr_valid = 0;
    #1;
    chk("flush_idle_ready", {31'b0, bus.o_instr_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_valid", {31'b0, bus.o_op_valid}, 32'h0);
      @(negedge clk); #1;
    end

    // Reset asserted while VALID is held.
    @(negedge clk);
    bus.i_instr_valid = 1; bus.i_instr = mk(5'd2, 5'd1, 5'd12); bus.i_op_ready = 1;
    @(negedge clk); bus.i_instr_valid = 0; bus.i_op_ready = 0;
    wait_valid("rst_wait_valid");
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_valid", {31'b0, bus.o_op_valid}, 32'h0);
    chk("rst_mid_a", bus.o_op_a, 32'h0);
    chk("rst_mid_b", bus.o_op_b, 32'h0);
    chk("rst_mid_rd", {27'b0, bus.o_op_rd}, 32'h0);
    chk("rst_mid_addr_a", {27'b0, bus.o_rf_rd_addr_a}, 32'h0);
    chk("rst_mid_addr_b", {27'b0, bus.o_rf_rd_addr_b}, 32'h0);
    @(negedge clk); reset = 1'b0;
    bus.i_instr_valid = 1; bus.i_instr = mk(5'd1, 5'd2, 5'd13); bus.i_op_ready = 1;
    #1;
    chk("rst_no_pulse", {31'b0, bus.o_op_valid}, 32'h0);
    @(negedge clk); bus.i_instr_valid = 0; #1;
    chk("rst_lat1", {31'b0, bus.o_op_valid}, 32'h0);
    @(negedge clk); #1;
    chk("rst_lat2", {31'b0, bus.o_op_valid}, 32'h0);
    @(negedge clk); #1;
    chk("rst_first_accept", {31'b0, bus.o_op_valid}, 32'h1);
    chk("rst_first_rd", {27'b0, bus.o_op_rd}, 32'd13);

    // Random traffic, checked by the monitor against the model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      bus.i_instr_valid = ($urandom_range(0, 1) == 1);
      bus.i_instr       = $urandom;
      bus.i_op_ready    = ($urandom_range(0, 9) < 7);
      bus.i_flush       = ($urandom_range(0, 31) == 0);
      wb($urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom);
    end
    @(negedge clk);
    bus.i_instr_valid = 0; bus.i_flush = 0; wb(0, 0, 0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
